// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the execution controller and the core decoder.
package exec_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10,
      ST_HALT = 2'b11
   } exec_state_e;

   localparam logic [1:0] OP_JUMP  = 2'b11;
   localparam logic [1:0] JMP_SELF = 2'b11;

   // A jump whose target field selects the current PC spins forever.
   function automatic logic is_self_jump(input logic [7:0] instr);
      return (instr[7:6] == OP_JUMP) && (instr[1:0] == JMP_SELF);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, and a
// one-cycle pulse on each accepted rising edge of the debounced level.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
   input  logic CLK,
   input  logic reset,
   input  logic btn_i,
   output logic rise_o
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          rise_q, rise_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Synchronize the raw button into the clock domain.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
      end
   end

   // Accept a new level only after it has differed from the old one for
   // DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts.
   always_comb begin
      level_d = level_q;
      rise_d  = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Debouncer state registers.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/exec_controller.sv
// Step sequencer for the 8-bit core: turns run switch, step button and halt
// conditions into a one-cycle step_en pulse per committed instruction.
//
//  state | meaning
//  IDLE  | waiting for run switch or a debounced step press
//  RUN   | tick counter paces one step every TICK_DIV cycles
//  STEP  | single-cycle state carrying one manual step_en
//  HALT  | stopped on breakpoint or self-jump until run switch drops
module exec_controller
   import exec_ctrl_pkg::*;
#(
   parameter int unsigned TICK_DIV        = 50_000_000,
   parameter int unsigned DEBOUNCE_CYCLES = 500_000,
   parameter int unsigned CNT_W           = 16
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             run_sw,
   input  logic             step_btn,
   input  logic             bp_en,
   input  logic [7:0]       bp_addr,
   input  logic [7:0]       pc,
   input  logic [7:0]       instruction,
   output logic             step_en,
   output logic [1:0]       state,
   output logic             halted,
   output logic             running_led,
   output logic [CNT_W-1:0] instr_count
);

   localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   exec_state_e      state_q, state_d;
   logic [TW-1:0]    tick_q, tick_d;
   logic             run_s1_q, run_sync_q;
   logic             step_req;
   logic             step_en_q, step_en_d;
   logic             halted_q, halted_d;
   logic             led_q, led_d;
   logic             bp_skip_q, bp_skip_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             halt_cond;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_step_db (
      .CLK   (CLK),
      .reset (reset),
      .btn_i (step_btn),
      .rise_o(step_req)
   );

   // Synchronize the run switch.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         run_s1_q   <= 1'b0;
         run_sync_q <= 1'b0;
      end else begin
         run_s1_q   <= run_sw;
         run_sync_q <= run_s1_q;
      end
   end

   // bp_skip lets a resume execute the breakpointed instruction once.
   assign halt_cond = (bp_en && (pc == bp_addr) && !bp_skip_q) || is_self_jump(instruction);

   // Next-state and registered-output logic.
   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      step_en_d = 1'b0;
      led_d     = led_q;
      bp_skip_d = bp_skip_q;
      case (state_q)
         ST_IDLE: begin
            if (run_sync_q) begin
               state_d = ST_RUN;
               tick_d  = '0;
            end else if (step_req) begin
               state_d   = ST_STEP;
               step_en_d = 1'b1;
            end
         end
         ST_STEP: state_d = ST_IDLE;
         ST_RUN: begin
            if (!run_sync_q) begin
               state_d = ST_IDLE;
            end else if (tick_q == TICK_LAST) begin
               tick_d = '0;
               if (halt_cond) begin
                  state_d = ST_HALT;
               end else begin
                  step_en_d = 1'b1;
                  led_d     = ~led_q;
               end
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         ST_HALT: begin
            if (!run_sync_q) begin
               state_d   = ST_IDLE;
               bp_skip_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (state_d != ST_RUN) led_d = 1'b0;
      if (step_en_d) bp_skip_d = 1'b0;
      halted_d = (state_d == ST_HALT);
      cnt_d    = (step_en_d && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         tick_q    <= '0;
         step_en_q <= 1'b0;
         halted_q  <= 1'b0;
         led_q     <= 1'b0;
         bp_skip_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         step_en_q <= step_en_d;
         halted_q  <= halted_d;
         led_q     <= led_d;
         bp_skip_q <= bp_skip_d;
         cnt_q     <= cnt_d;
      end
   end

   assign step_en     = step_en_q;
   assign state       = state_q;
   assign halted      = halted_q;
   assign running_led = led_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_exec_controller.sv
// Bench for exec_controller with TICK_DIV=4, DEBOUNCE_CYCLES=3, CNT_W=4.
// Expected step_en pulses (cycle and count) are queued as stimulus is driven
// and consumed by a monitor whenever step_en is seen high.
module tb_exec_controller;

   localparam int TICK_DIV = 4;
   localparam int DEB      = 3;
   localparam int CNT_W    = 4;
   localparam int CNT_MAX  = 15;

   typedef struct {
      int cyc;
      int cnt;
   } exp_t;

   logic             CLK = 1'b0;
   logic             reset = 1'b0;
   logic             run_sw = 1'b0;
   logic             step_btn = 1'b0;
   logic             bp_en = 1'b0;
   logic [7:0]       bp_addr = 8'h00;
   logic [7:0]       pc = 8'h00;
   logic [7:0]       instruction = 8'h00;
   logic             step_en;
   logic [1:0]       state;
   logic             halted;
   logic             running_led;
   logic [CNT_W-1:0] instr_count;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   model_cnt = 0;
   exp_t exp_q[$];

   exec_controller #(
      .TICK_DIV       (TICK_DIV),
      .DEBOUNCE_CYCLES(DEB),
      .CNT_W          (CNT_W)
   ) dut (
      .CLK        (CLK),
      .reset      (reset),
      .run_sw     (run_sw),
      .step_btn   (step_btn),
      .bp_en      (bp_en),
      .bp_addr    (bp_addr),
      .pc         (pc),
      .instruction(instruction),
      .step_en    (step_en),
      .state      (state),
      .halted     (halted),
      .running_led(running_led),
      .instr_count(instr_count)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic wait_neg(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic push_step(input int c);
      exp_t e;
      model_cnt = (model_cnt == CNT_MAX) ? CNT_MAX : model_cnt + 1;
      e.cyc = c;
      e.cnt = model_cnt;
      exp_q.push_back(e);
   endtask

   task automatic apply_reset();
      run_sw = 0; step_btn = 0; bp_en = 0; bp_addr = 8'h00; pc = 8'h00; instruction = 8'h00;
      @(negedge CLK);
      reset = 0;
      wait_neg(3);
      reset = 1;
      model_cnt = 0;
      exp_q.delete();
      wait_neg(2);
   endtask

   task automatic test_reset();
      int k;
      apply_reset();
      checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got=%b required=00", state); end
      checks++; if (step_en !== 1'b0 || halted !== 1'b0 || running_led !== 1'b0) begin errors++;
         $display("FAIL reset_flags got step_en=%b halted=%b led=%b required 0 0 0", step_en, halted, running_led); end
      checks++; if (instr_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d required=0", instr_count); end
      pc = 8'h05;
      k = cyc; run_sw = 1;
      push_step(k + 7); push_step(k + 11);
      wait_neg(13);
      checks++; if (running_led !== 1'b0) begin errors++; $display("FAIL midrun_led got=%b required=0", running_led); end
      reset = 0; #1;
      checks++; if (state !== 2'b00 || step_en !== 1'b0 || instr_count !== 4'd0 || running_led !== 1'b0) begin errors++;
         $display("FAIL midrun_reset got state=%b step_en=%b count=%0d led=%b required 00 0 0 0", state, step_en, instr_count, running_led); end
      run_sw = 0; model_cnt = 0;
      wait_neg(2); reset = 1; wait_neg(2);
      checks++; if (state !== 2'b00 || instr_count !== 4'd0) begin errors++;
         $display("FAIL post_reset got state=%b count=%0d required 00 0", state, instr_count); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL reset_pending got=%0d required=0", exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_run();
      int k;
      apply_reset();
      pc = 8'h05; instruction = 8'h00; bp_en = 0;
      k = cyc; run_sw = 1;
      push_step(k + 7); push_step(k + 11); push_step(k + 15);
      wait_neg(3);
      checks++; if (state !== 2'b01) begin errors++; $display("FAIL run_enter got=%b required=01", state); end
      wait_neg(13);
      checks++; if (instr_count !== 4'd3) begin errors++; $display("FAIL run_count got=%0d required=3", instr_count); end
      checks++; if (running_led !== 1'b1) begin errors++; $display("FAIL run_led got=%b required=1", running_led); end
      run_sw = 0;
      wait_neg(4);
      checks++; if (state !== 2'b00 || running_led !== 1'b0) begin errors++;
         $display("FAIL run_exit got state=%b led=%b required 00 0", state, running_led); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL run_pending got=%0d required=0", exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_breakpoint();
      int k;
      apply_reset();
      bp_en = 1; bp_addr = 8'h05; pc = 8'h05; instruction = 8'h00;
      run_sw = 1;
      wait_neg(8);
      checks++; if (state !== 2'b11 || halted !== 1'b1) begin errors++;
         $display("FAIL bp_halt got state=%b halted=%b required 11 1", state, halted); end
      run_sw = 0;
      wait_neg(3);
      checks++; if (state !== 2'b00 || halted !== 1'b0) begin errors++;
         $display("FAIL bp_idle got state=%b halted=%b required 00 0", state, halted); end
      k = cyc; push_step(k + 6); step_btn = 1;
      wait_neg(8); step_btn = 0; wait_neg(6);
      checks++; if (instr_count !== 4'd1) begin errors++; $display("FAIL bp_step_count got=%0d required=1", instr_count); end
      run_sw = 1;
      wait_neg(8);
      checks++; if (state !== 2'b11) begin errors++; $display("FAIL bp_skip_cleared got=%b required=11", state); end
      run_sw = 0;
      wait_neg(4);
      k = cyc; run_sw = 1; push_step(k + 7);
      wait_neg(12);
      checks++; if (state !== 2'b11) begin errors++; $display("FAIL bp_resume_halt got=%b required=11", state); end
      run_sw = 0;
      wait_neg(4);
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_pending got=%0d required=0", exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_self_jump();
      int k;
      apply_reset();
      pc = 8'h20; bp_en = 0; instruction = 8'hC1;
      k = cyc; run_sw = 1; push_step(k + 7);
      wait_neg(8);
      checks++; if (state !== 2'b01) begin errors++; $display("FAIL jmp_not_self got=%b required=01", state); end
      run_sw = 0;
      wait_neg(4);
      instruction = 8'hC3;
      run_sw = 1;
      wait_neg(8);
      checks++; if (state !== 2'b11 || halted !== 1'b1) begin errors++;
         $display("FAIL jmp_halt got state=%b halted=%b required 11 1", state, halted); end
      step_btn = 1; wait_neg(8); step_btn = 0; wait_neg(8);
      checks++; if (state !== 2'b11) begin errors++; $display("FAIL jmp_halt_hold got=%b required=11", state); end
      run_sw = 0;
      wait_neg(4);
      k = cyc; push_step(k + 6); step_btn = 1;
      wait_neg(8); step_btn = 0; wait_neg(6);
      checks++; if (instr_count !== 4'd2) begin errors++; $display("FAIL jmp_step_count got=%0d required=2", instr_count); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL jmp_pending got=%0d required=0", exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_debounce();
      int k;
      apply_reset();
      instruction = 8'h00;
      step_btn = 1; wait_neg(2); step_btn = 0; wait_neg(8);
      k = cyc; push_step(k + 6); step_btn = 1;
      wait_neg(3); step_btn = 0; wait_neg(8);
      k = cyc; step_btn = 1; wait_neg(1); step_btn = 0; wait_neg(1); step_btn = 1;
      push_step(k + 8);
      wait_neg(10); step_btn = 0; wait_neg(8);
      k = cyc; push_step(k + 6); step_btn = 1;
      wait_neg(5); step_btn = 0; wait_neg(6);
      checks++; if (instr_count !== 4'd3) begin errors++; $display("FAIL deb_count got=%0d required=3", instr_count); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL deb_pending got=%0d required=0", exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_same_cycle();
      apply_reset();
      instruction = 8'h00;
      step_btn = 1; wait_neg(3); run_sw = 1; wait_neg(3);
      checks++; if (state !== 2'b01 || step_en !== 1'b0) begin errors++;
         $display("FAIL same_idle got state=%b step_en=%b required 01 0", state, step_en); end
      wait_neg(1); run_sw = 0; wait_neg(2);
      checks++; if (state !== 2'b01) begin errors++; $display("FAIL same_run_hold got=%b required=01", state); end
      wait_neg(1);
      checks++; if (state !== 2'b00 || step_en !== 1'b0) begin errors++;
         $display("FAIL same_tick_stop got state=%b step_en=%b required 00 0", state, step_en); end
      step_btn = 0; wait_neg(8);
      checks++; if (instr_count !== 4'd0) begin errors++; $display("FAIL same_count got=%0d required=0", instr_count); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL same_pending got=%0d required=0", exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_saturation();
      int k;
      apply_reset();
      instruction = 8'h00;
      k = cyc; run_sw = 1;
      for (int i = 0; i < 18; i++) push_step(k + 7 + 4 * i);
      wait_neg(76);
      checks++; if (instr_count !== 4'd15) begin errors++; $display("FAIL sat_count got=%0d required=15", instr_count); end
      run_sw = 0;
      wait_neg(4);
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sat_pending got=%0d required=0", exp_q.size()); end
      exp_q.delete();
   endtask

   initial begin
      fork
         forever begin
            exp_t e;
            @(negedge CLK);
            if (reset === 1'b1 && step_en !== 1'b0) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL step_en_unexpected cyc=%0d got step_en=%b required no pulse", cyc, step_en);
               end else begin
                  e = exp_q.pop_front();
                  if (cyc != e.cyc || instr_count !== CNT_W'(e.cnt)) begin
                     errors++;
                     $display("FAIL step_en_event got cyc=%0d count=%0d required cyc=%0d count=%0d",
                              cyc, instr_count, e.cyc, e.cnt);
                  end
               end
            end
         end
      join_none
      test_reset();
      test_run();
      test_breakpoint();
      test_self_jump();
      test_debounce();
      test_same_cycle();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got time=%0t required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
